cmp_seq_unit: RTL

Sequential, parametrised successor to the ALU combinational compare block. It compares two operands chunk-by-chunk from the most significant chunk down, in unsigned or signed mode. It returns the min or max operand together with above/below/equal flags. Operands enter and results leave through valid/ready handshakes, so the unit can sit in a multi-cycle ALU slot where a full-width single-cycle comparator would limit timing.

---
 rtl/cmp_seq_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cmp_seq_unit.sv
// cmp_seq_unit: sequential chunk-serial magnitude comparator with min/max select.
// Operands are compared one CHUNK_WIDTH slice per cycle, starting at the most
// significant chunk, in unsigned or two's-complement mode.
// Optional feature macro: CMP_EARLY_EXIT_EN
//   defined   - the scan stops at the first differing chunk (data-dependent latency)
//   undefined - the scan always covers all chunks (constant latency, same results)
module cmp_seq_unit #(
  parameter int WORD_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            op_i,
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [WORD_WIDTH-1:0] r_o,
  output logic                  above_o,
  output logic                  below_o,
  output logic                  zf_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int N  = WORD_WIDTH / CHUNK_WIDTH;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_MSB = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state;
  logic [WORD_WIDTH-1:0]   a_q;
  logic [WORD_WIDTH-1:0]   b_q;
  logic [1:0]              op_q;
  logic [KW-1:0]           k;

  logic [CHUNK_WIDTH-1:0]  chunk_a;
  logic [CHUNK_WIDTH-1:0]  chunk_b;
  logic                    chunk_gt;
  logic                    chunk_lt;
  logic                    scan_done;
  logic                    fin_gt;
  logic                    fin_lt;

`ifndef CMP_EARLY_EXIT_EN
  // First difference seen from the MSB side; later chunks must not overwrite it.
  logic                    found;
  logic                    gt_q;
  logic                    lt_q;
`endif

  // Min/max selection: below picks A for min and B for max; equal operands give A.
  function automatic logic [WORD_WIDTH-1:0] select_result(
    input logic                  lt,
    input logic                  sel_max,
    input logic [WORD_WIDTH-1:0] a,
    input logic [WORD_WIDTH-1:0] b
  );
    if (lt) return sel_max ? b : a;
    else    return sel_max ? a : b;
  endfunction

  // Current chunk compare; signed mode biases the sign bit so an unsigned compare works.
  always_comb begin
    chunk_a = a_q[int'(k)*CHUNK_WIDTH +: CHUNK_WIDTH];
    chunk_b = b_q[int'(k)*CHUNK_WIDTH +: CHUNK_WIDTH];
    if (op_q[0] && (k == K_MSB)) begin
      chunk_a[CHUNK_WIDTH-1] = ~chunk_a[CHUNK_WIDTH-1];
      chunk_b[CHUNK_WIDTH-1] = ~chunk_b[CHUNK_WIDTH-1];
    end
    chunk_gt = (chunk_a > chunk_b);
    chunk_lt = (chunk_a < chunk_b);
  end

  // Decide whether this SCAN cycle ends the scan and which flags it delivers.
  always_comb begin
`ifdef CMP_EARLY_EXIT_EN
    scan_done = chunk_gt | chunk_lt | (k == '0);
    fin_gt    = chunk_gt;
    fin_lt    = chunk_lt;
`else
    scan_done = (k == '0);
    fin_gt    = found ? gt_q : chunk_gt;
    fin_lt    = found ? lt_q : chunk_lt;
`endif
  end

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      r_o     <= '0;
      above_o <= 1'b0;
      below_o <= 1'b0;
      zf_o    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      k       <= '0;
`ifndef CMP_EARLY_EXIT_EN
      found   <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            a_q     <= a_i;
            b_q     <= b_i;
            op_q    <= op_i;
            k       <= K_MSB;
            ready_o <= 1'b0;
            state   <= SCAN;
`ifndef CMP_EARLY_EXIT_EN
            found   <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
`endif
          end
        end
        SCAN: begin
          if (scan_done) begin
            above_o <= fin_gt;
            below_o <= fin_lt;
            zf_o    <= ~(fin_gt | fin_lt);
            r_o     <= select_result(fin_lt, op_q[1], a_q, b_q);
            valid_o <= 1'b1;
            state   <= DONE;
          end else begin
`ifndef CMP_EARLY_EXIT_EN
            if (!found && (chunk_gt || chunk_lt)) begin
              found <= 1'b1;
              gt_q  <= chunk_gt;
              lt_q  <= chunk_lt;
            end
`endif
            k <= k - 1'b1;
          end
        end
        DONE: begin
          if (valid_o && ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
